// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - VRAM port A arbiter between the host slave path and the fill/scroll engine
//
// Ports:
//   CLK, RESET_N                   clock, asynchronous active-low reset
//   H_READ/H_WRITE/H_CS/H_BYTE_EN  host request (VRAM range only)
//   H_ADDR, H_WRITEDATA            host word address and write data
//   H_READDATA, H_WAITREQUEST      host read data and stall
//   CMD_VALID/CMD_OP/CMD_FILL      engine command (0 = CLEAR, 1 = SCROLL) and fill word
//   CMD_READY, BUSY, DONE          engine status
//   RAM_ADDR/RAM_BYTE_EN/RAM_WDATA/RAM_WREN/RAM_Q  VRAM port A (1-cycle registered read)
module vram_port_arbiter #(
   parameter int WORDS      = 600,
   parameter int ROW_WORDS  = 40,
   parameter int STARVE_MAX = 8
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        H_READ,
   input  logic        H_WRITE,
   input  logic        H_CS,
   input  logic [3:0]  H_BYTE_EN,
   input  logic [9:0]  H_ADDR,
   input  logic [31:0] H_WRITEDATA,
   output logic [31:0] H_READDATA,
   output logic        H_WAITREQUEST,
   input  logic        CMD_VALID,
   input  logic        CMD_OP,
   input  logic [31:0] CMD_FILL,
   output logic        CMD_READY,
   output logic        BUSY,
   output logic        DONE,
   output logic [9:0]  RAM_ADDR,
   output logic [3:0]  RAM_BYTE_EN,
   output logic [31:0] RAM_WDATA,
   output logic        RAM_WREN,
   input  logic [31:0] RAM_Q
);

   localparam int              SW          = $clog2(STARVE_MAX + 1);
   localparam logic [9:0]      LAST_IDX    = 10'(WORDS - 1);
   localparam logic [9:0]      SC_LAST_IDX = 10'(WORDS - ROW_WORDS - 1);
   localparam logic [9:0]      TAIL_IDX    = 10'(WORDS - ROW_WORDS);
   localparam logic [9:0]      ROW_OFS     = 10'(ROW_WORDS);
   localparam logic [SW-1:0]   STARVE_LIM  = SW'(STARVE_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR_WR, S_SC_RD, S_SC_CAP, S_SC_WR, S_FILL, S_DONE
   } state_t;

   state_t        state, state_n;
   logic [9:0]    idx, idx_n;
   logic [31:0]   fill_q;
   logic [31:0]   hold_q;
   logic [31:0]   rd_hold;
   logic          host_pend;
   logic [SW-1:0] starve;

   logic host_req, eng_want, eng_force, eng_gnt, host_gnt;

   // A pending host read masks the request so the second cycle of a read
   // leaves the port free for the engine.
   assign host_req  = H_CS & (H_READ | H_WRITE) & ~host_pend;
   assign eng_want  = (state == S_CLR_WR) || (state == S_SC_RD) ||
                      (state == S_SC_WR)  || (state == S_FILL);
   assign eng_force = eng_want && (starve == STARVE_LIM);
   assign eng_gnt   = eng_want && (!host_req || eng_force);
   assign host_gnt  = host_req && !eng_force;

   assign CMD_READY = (state == S_IDLE);
   assign BUSY      = (state != S_IDLE);
   assign DONE      = (state == S_DONE);

   // Read data is RAM_Q itself in the completing cycle, then held until the next read.
   assign H_READDATA    = host_pend ? RAM_Q : rd_hold;
   // H_READ has priority, so a request with both strobes set is a read.
   assign H_WAITREQUEST = host_req && (!host_gnt || H_READ);

   always_comb begin
      RAM_ADDR    = '0;
      RAM_BYTE_EN = '0;
      RAM_WDATA   = '0;
      RAM_WREN    = 1'b0;
      if (eng_gnt) begin
         RAM_BYTE_EN = 4'hF;
         case (state)
            S_CLR_WR, S_FILL: begin
               RAM_ADDR  = idx;
               RAM_WDATA = fill_q;
               RAM_WREN  = 1'b1;
            end
            S_SC_RD: RAM_ADDR = idx + ROW_OFS;
            S_SC_WR: begin
               RAM_ADDR  = idx;
               RAM_WDATA = hold_q;
               RAM_WREN  = 1'b1;
            end
            default: RAM_BYTE_EN = '0;
         endcase
      end else if (host_gnt) begin
         RAM_ADDR    = H_ADDR;
         RAM_BYTE_EN = H_BYTE_EN;
         if (!H_READ) begin
            RAM_WDATA = H_WRITEDATA;
            RAM_WREN  = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         S_IDLE: begin
            if (CMD_VALID) begin
               idx_n   = '0;
               state_n = CMD_OP ? S_SC_RD : S_CLR_WR;
            end
         end
         S_CLR_WR, S_FILL: begin
            if (eng_gnt) begin
               if (idx == LAST_IDX) state_n = S_DONE;
               else                 idx_n   = idx + 10'd1;
            end
         end
         S_SC_RD: begin
            if (eng_gnt) state_n = S_SC_CAP;
         end
         // RAM_Q here is the engine's own read from the previous cycle.
         S_SC_CAP: state_n = S_SC_WR;
         S_SC_WR: begin
            if (eng_gnt) begin
               if (idx == SC_LAST_IDX) begin
                  state_n = S_FILL;
                  idx_n   = TAIL_IDX;
               end else begin
                  state_n = S_SC_RD;
                  idx_n   = idx + 10'd1;
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= S_IDLE;
         idx       <= '0;
         fill_q    <= '0;
         hold_q    <= '0;
         rd_hold   <= '0;
         host_pend <= 1'b0;
         starve    <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         host_pend <= host_gnt && H_READ;
         if (state == S_IDLE && CMD_VALID) fill_q  <= CMD_FILL;
         if (state == S_SC_CAP)            hold_q  <= RAM_Q;
         if (host_pend)                    rd_hold <= RAM_Q;
         // Saturates at STARVE_LIM because that value forces the next engine grant.
         if (state == S_IDLE || eng_gnt) starve <= '0;
         else if (eng_want)              starve <= starve + SW'(1);
      end
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - directed scoreboard bench for vram_port_arbiter
module tb_vram_port_arbiter;

   localparam int WORDS = 600;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        H_READ, H_WRITE, H_CS;
   logic [3:0]  H_BYTE_EN;
   logic [9:0]  H_ADDR;
   logic [31:0] H_WRITEDATA;
   logic [31:0] H_READDATA;
   logic        H_WAITREQUEST;
   logic        CMD_VALID, CMD_OP;
   logic [31:0] CMD_FILL;
   logic        CMD_READY, BUSY, DONE;
   logic [9:0]  RAM_ADDR;
   logic [3:0]  RAM_BYTE_EN;
   logic [31:0] RAM_WDATA;
   logic        RAM_WREN;
   logic [31:0] RAM_Q;

   vram_port_arbiter dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .H_READ(H_READ), .H_WRITE(H_WRITE), .H_CS(H_CS), .H_BYTE_EN(H_BYTE_EN),
      .H_ADDR(H_ADDR), .H_WRITEDATA(H_WRITEDATA), .H_READDATA(H_READDATA),
      .H_WAITREQUEST(H_WAITREQUEST),
      .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_FILL(CMD_FILL),
      .CMD_READY(CMD_READY), .BUSY(BUSY), .DONE(DONE),
      .RAM_ADDR(RAM_ADDR), .RAM_BYTE_EN(RAM_BYTE_EN), .RAM_WDATA(RAM_WDATA),
      .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q)
   );

   always #10 CLK = ~CLK;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // VRAM port A: registered read, byte-enabled write.
   logic [31:0] vram [WORDS];
   always_ff @(posedge CLK) begin
      if (RAM_WREN && RAM_ADDR < 10'(WORDS))
         vram[RAM_ADDR] <= merge(vram[RAM_ADDR], RAM_WDATA, RAM_BYTE_EN);
      RAM_Q <= (RAM_ADDR < 10'(WORDS)) ? vram[RAM_ADDR] : 32'h0;
   end

   logic [31:0] exp_mem [WORDS];
   logic [31:0] rd_q [$];
   int n_pass = 0, n_fail = 0, n_total = 0;

   logic        snap_wait, snap_wren1, rd_done;
   logic [9:0]  snap_addr0, snap_addr1;
   logic [31:0] snap_wdata1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mem_check(input string tag);
      int bad;
      bad = 0;
      for (int k = 0; k < WORDS; k++) if (vram[k] !== exp_mem[k]) bad++;
      check(tag, bad, 0);
   endtask

   task automatic host_idle();
      H_CS = 0; H_READ = 0; H_WRITE = 0; H_BYTE_EN = 0; H_ADDR = 0; H_WRITEDATA = 0;
   endtask

   // Entered and left just after a rising edge; request stays asserted until the caller changes it.
   task automatic host_op(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] be, output int lat);
      H_CS = 1; H_READ = rd; H_WRITE = wr; H_ADDR = a; H_WRITEDATA = d; H_BYTE_EN = be;
      if (rd) rd_q.push_back(exp_mem[a]);
      else    exp_mem[a] = merge(exp_mem[a], d, be);
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         lat = i + 1;
         if (!H_WAITREQUEST) begin
            if (rd) check("host_rd_data", H_READDATA, rd_q.pop_front());
            @(posedge CLK); #1;
            return;
         end
         @(posedge CLK); #1;
      end
      lat = -1;
      check("host_op_timeout", H_WAITREQUEST, 0);
   endtask

   task automatic run_cmd(input logic op, input logic [31:0] fill, input int rd_cyc,
                          input logic [9:0] rd_addr, output int done_c, output int wr_cnt,
                          output int pulses);
      logic rd_active;
      rd_active = 0; done_c = -1; wr_cnt = 0; pulses = 0; rd_done = 0;
      CMD_VALID = 1; CMD_OP = op; CMD_FILL = fill;
      for (int c = 0; c < 6000; c++) begin
         if (c == rd_cyc) begin
            H_CS = 1; H_READ = 1; H_WRITE = 0; H_ADDR = rd_addr; H_BYTE_EN = 4'hF;
            rd_q.push_back(exp_mem[rd_addr]);
            rd_active = 1;
         end
         @(negedge CLK);
         if (RAM_WREN) wr_cnt++;
         if (DONE) begin pulses++; done_c = c; end
         if (c == rd_cyc) begin snap_wait = H_WAITREQUEST; snap_addr0 = RAM_ADDR; end
         if (rd_cyc >= 0 && c == rd_cyc + 1) begin
            snap_addr1 = RAM_ADDR; snap_wdata1 = RAM_WDATA; snap_wren1 = RAM_WREN;
         end
         if (rd_active && !H_WAITREQUEST) begin
            check("eng_rd_data", H_READDATA, rd_q.pop_front());
            rd_active = 0; rd_done = 1;
         end
         if (c > 0 && CMD_READY && !rd_active) begin
            @(posedge CLK); #1; host_idle();
            return;
         end
         @(posedge CLK); #1;
         CMD_VALID = 0;
         if (!rd_active) host_idle();
      end
      check("cmd_timeout", CMD_READY, 1);
   endtask

   task automatic wait_done(output int pulses);
      pulses = 0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge CLK);
         if (DONE) pulses++;
         if (CMD_READY) begin @(posedge CLK); #1; return; end
         @(posedge CLK); #1;
      end
      check("done_timeout", CMD_READY, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, dc, wc, pc, bad, host_val, found;
      logic [31:0] old41, fill5;
      logic [31:0] snap [WORDS];

      RESET_N = 0; CMD_VALID = 0; CMD_OP = 0; CMD_FILL = 0;
      host_idle();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_cmd_ready", CMD_READY, 1);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_wait", H_WAITREQUEST, 0);
      check("rst_wren", RAM_WREN, 0);
      check("rst_addr", RAM_ADDR, 0);
      check("rst_rdata", H_READDATA, 0);
      @(posedge CLK); #1;
      RESET_N = 1;

      // Idle host write then read, byte-enable write, read+write treated as read.
      host_op(0, 1, 10'd5, 32'hA5A5_0041, 4'hF, lat);
      check("idle_wr_lat", lat, 1);
      host_op(1, 0, 10'd5, 32'h0, 4'hF, lat);
      check("idle_rd_lat", lat, 2);
      host_op(0, 1, 10'd5, 32'hFFFF_FFFF, 4'b0010, lat);
      host_op(1, 0, 10'd5, 32'h0, 4'hF, lat);
      host_op(1, 1, 10'd5, 32'h1234_5678, 4'hF, lat);
      check("rdwr_lat", lat, 2);
      host_op(1, 0, 10'd5, 32'h0, 4'hF, lat);
      host_idle();

      // CLEAR with no host traffic.
      run_cmd(0, 32'h0000_0F00, -1, 10'd0, dc, wc, pc);
      check("clr_done_cyc", dc, 601);
      check("clr_writes", wc, 600);
      check("clr_pulses", pc, 1);
      for (int k = 0; k < WORDS; k++) exp_mem[k] = 32'h0000_0F00;
      mem_check("clr_mem");

      // Preload k, SCROLL with zero fill.
      for (int k = 0; k < WORDS; k++) host_op(0, 1, 10'(k), 32'(k), 4'hF, lat);
      host_idle();
      mem_check("preload_mem");
      run_cmd(1, 32'h0, -1, 10'd0, dc, wc, pc);
      check("sc_pulses", pc, 1);
      check("sc_writes", wc, 600);
      for (int k = 0; k < WORDS; k++) snap[k] = exp_mem[k];
      for (int k = 0; k < WORDS; k++) exp_mem[k] = (k < WORDS - 40) ? snap[k + 40] : 32'h0;
      mem_check("sc_mem");

      // SCROLL with a host read @45 landing on the first-row SC_CAP cycle (cycle 5).
      old41 = exp_mem[41];
      run_cmd(1, 32'hDEAD_0000, 5, 10'd45, dc, wc, pc);
      check("cap_rd_done", rd_done, 1);
      check("cap_rd_wait", snap_wait, 1);
      check("cap_rd_addr", snap_addr0, 45);
      check("cap_wr_addr", snap_addr1, 1);
      check("cap_wr_en", snap_wren1, 1);
      check("cap_hold_data", snap_wdata1, old41);
      check("cap_pulses", pc, 1);
      check("cap_writes", wc, 600);
      for (int k = 0; k < WORDS; k++) snap[k] = exp_mem[k];
      for (int k = 0; k < WORDS; k++) exp_mem[k] = (k < WORDS - 40) ? snap[k + 40] : 32'hDEAD_0000;
      mem_check("cap_mem");

      // CLEAR under back-to-back host writes to word 599: engine forced every 9th cycle.
      fill5 = 32'h0000_1E20;
      bad = 0; host_val = 0;
      CMD_VALID = 1; CMD_OP = 0; CMD_FILL = fill5;
      H_CS = 1; H_WRITE = 1; H_READ = 0; H_ADDR = 10'd599; H_BYTE_EN = 4'hF; H_WRITEDATA = 0;
      for (int c = 0; c < 90; c++) begin
         @(negedge CLK);
         if (c > 0 && c % 9 == 0) begin
            if (H_WAITREQUEST !== 1'b1 || RAM_WREN !== 1'b1 ||
                RAM_ADDR !== 10'(c / 9 - 1) || RAM_WDATA !== fill5) bad++;
         end else begin
            if (H_WAITREQUEST !== 1'b0 || RAM_WREN !== 1'b1 ||
                RAM_ADDR !== 10'd599 || RAM_WDATA !== 32'(host_val)) bad++;
            host_val++;
         end
         @(posedge CLK); #1;
         CMD_VALID = 0;
         H_WRITEDATA = 32'(host_val);
      end
      host_idle();
      check("starve_pattern", bad, 0);
      wait_done(pc);
      check("starve_pulses", pc, 1);
      for (int k = 0; k < WORDS; k++) exp_mem[k] = fill5;
      mem_check("starve_mem");

      // Reset in the middle of a SCROLL, then a fresh CLEAR.
      found = 0;
      CMD_VALID = 1; CMD_OP = 1; CMD_FILL = 32'h0;
      for (int i = 0; i < 1000 && found == 0; i++) begin
         @(negedge CLK);
         if (RAM_WREN && RAM_ADDR == 10'd100 && BUSY) found = 1;
         else begin @(posedge CLK); #1; CMD_VALID = 0; end
      end
      check("mid_found", found, 1);
      #1 RESET_N = 0;
      #1;
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_ready", CMD_READY, 1);
      check("mid_rst_wren", RAM_WREN, 0);
      @(posedge CLK); #1;
      RESET_N = 1;
      run_cmd(0, 32'h0000_0720, -1, 10'd0, dc, wc, pc);
      check("post_rst_done_cyc", dc, 601);
      check("post_rst_pulses", pc, 1);
      for (int k = 0; k < WORDS; k++) exp_mem[k] = 32'h0000_0720;
      mem_check("post_rst_mem");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
